// File: rtl/ram_model_pkg.sv
// Shared types and constants for the ram_model backing-memory model.
package ram_model_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  localparam int LINE_BITS      = 512;
  localparam int OFFSET_BITS    = 6;
  localparam int WORDS_PER_LINE = LINE_BITS / 32;

  // Pattern returned for a line that has never been written: the line base address repeated.
  function automatic logic [LINE_BITS-1:0] default_line(input logic [31:0] addr);
    logic [31:0] base;
    base = addr & ~32'((2 ** OFFSET_BITS) - 1);
    return {WORDS_PER_LINE{base}};
  endfunction

endpackage

// File: rtl/ram_model_line_store.sv
// Line-granular backing store: DEPTH lines of 512 bits with per-line valid bits.
module ram_line_store
  import ram_model_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [IDX_W-1:0]     waddr,
  input  logic [LINE_BITS-1:0] wdata,
  input  logic [IDX_W-1:0]     raddr,
  output logic [LINE_BITS-1:0] rdata,
  output logic                 rvalid
);

  logic [LINE_BITS-1:0] mem [DEPTH];
  logic [DEPTH-1:0]     valid;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     valid <= '0;
    else if (we) valid[waddr] <= 1'b1;
  end

  assign rdata  = mem[raddr];
  assign rvalid = valid[raddr];

endmodule

// File: rtl/ram_model.sv
// Backing-memory model: programmable-latency fills and write-backs with a one-cycle ready pulse.
module ram_model
  import ram_model_pkg::*;
#(
  parameter int LATENCY    = 8,
  parameter int WB_LATENCY = 8,
  parameter int DEPTH      = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ram_req,
  input  logic [31:0]          ram_address,
  input  logic                 ram_we,
  input  logic [LINE_BITS-1:0] ram_write_data,
  output logic                 ram_ready,
  output logic [LINE_BITS-1:0] ram_read_data,
  output logic                 busy,
  output logic [31:0]          read_count,
  output logic [31:0]          write_count
);

  localparam int          IDX_W   = $clog2(DEPTH);
  localparam logic [31:0] RD_LOAD = 32'(LATENCY - 1);
  localparam logic [31:0] WR_LOAD = 32'(WB_LATENCY - 1);

  state_t               state, next_state;
  logic [31:0]          cnt, cnt_next;
  logic [31:0]          addr_p1;
  logic                 we_p1;
  logic [LINE_BITS-1:0] wdata_p1;
  logic [31:0]          tx_addr;
  logic                 tx_we;
  logic [LINE_BITS-1:0] tx_wdata;
  logic [IDX_W-1:0]     tx_idx;
  logic [LINE_BITS-1:0] store_rdata;
  logic                 store_rvalid;
  logic [LINE_BITS-1:0] fill_line;
  logic                 enter_respond;

  // In IDLE the live request is used so a zero-wait transaction can respond next cycle.
  assign tx_addr  = (state == ST_IDLE) ? ram_address    : addr_p1;
  assign tx_we    = (state == ST_IDLE) ? ram_we         : we_p1;
  assign tx_wdata = (state == ST_IDLE) ? ram_write_data : wdata_p1;
  assign tx_idx   = tx_addr[IDX_W+OFFSET_BITS-1:OFFSET_BITS];

  assign enter_respond = (next_state == ST_RESPOND);
  assign fill_line     = store_rvalid ? store_rdata : default_line(tx_addr);

  // cnt holds the number of ACCESS cycles still to run, including the current one.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        if (ram_req) begin
          cnt_next   = ram_we ? WR_LOAD : RD_LOAD;
          next_state = (cnt_next == '0) ? ST_RESPOND : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!ram_req) begin
          next_state = ST_IDLE;
        end else begin
          cnt_next = cnt - 32'd1;
          if (cnt == 32'd1) next_state = ST_RESPOND;
        end
      end
      ST_RESPOND: next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Request capture stage
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && ram_req) begin
      addr_p1  <= ram_address;
      we_p1    <= ram_we;
      wdata_p1 <= ram_write_data;
    end
  end

  ram_line_store #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_store (
    .clk    (clk),
    .rst    (rst),
    .we     (enter_respond && tx_we),
    .waddr  (tx_idx),
    .wdata  (tx_wdata),
    .raddr  (tx_idx),
    .rdata  (store_rdata),
    .rvalid (store_rvalid)
  );

  // Registered outputs stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      ram_ready     <= 1'b0;
      busy          <= 1'b0;
      ram_read_data <= '0;
      read_count    <= '0;
      write_count   <= '0;
    end else begin
      state         <= next_state;
      cnt           <= cnt_next;
      ram_ready     <= enter_respond;
      busy          <= (next_state != ST_IDLE);
      ram_read_data <= (enter_respond && !tx_we) ? fill_line : '0;
      if (enter_respond) begin
        if (tx_we) write_count <= write_count + 32'd1;
        else       read_count  <= read_count + 32'd1;
      end
    end
  end

endmodule
